instr_word_encoder: RTL and testbench
=====================================

# instr_word_encoder

- Sequential encoder: accepts abstract operation requests and emits 16-bit WISC-SP19 instruction words, one per valid/ready handshake.
- Works in the opposite direction to the control decoder. It feeds the decoder's opcode input from a request stream, for self-checking program generation and instruction-memory preload.
- Expands a 16-bit constant load into an LBI/SLBI pair (or a single LBI when the value fits), and terminates the stream with HALT.

## Interface
- `NOP_WORD`, 16'h0800, instruction word emitted for nop requests (opcode 00001).
- `clk` in 1 system clock, rising edge.
- `rst` in 1 asynchronous reset, active-low.
- `req_valid` in 1 request present.
- `req_ready` out 1 request accepted this cycle when `req_valid && req_ready`.
- `req_kind` in 2 request type:
  - 00 raw word
  - 01 load constant
  - 10 halt
  - 11 nop
- `req_rd` in 3 destination register for load constant.
- `req_data` in 16 raw instruction word (kind 00) or constant (kind 01).
- `out_valid` out 1 `out_instr` valid.
- `out_ready` in 1 consumer accepts word.
- `out_instr` out 16 encoded instruction.
- `out_last` out 1 the current word is the final word of its request.
- `instr_count` out 16 number of words handed off, wraps at 16'hFFFF→0.
- `halted` out 1 the HALT word has been handed off.
- `err` out 1 sticky: a raw request carried opcode 00000.

## Operation
- States:
  - IDLE: accepts requests.
  - EMIT_HI: first word of the pair presented.
  - EMIT_LO: second word pending/presented.
  - HALTED: terminal.
- `req_ready = (state==IDLE) && (!out_valid || out_ready)`.
- On accept, by request kind:
  - Raw: `out_instr = req_data`, `out_last=1`.
    - If `req_data[15:11]==5'b00000`, set `err`.
    - Replace the word with `NOP_WORD`, so HALT is only produced via kind 10.
  - Load constant, when `req_data[15:7]` is all zeros or all ones: single word `{5'b11000, rd, data[7:0]}` (LBI), `out_last=1`.
  - Load constant otherwise:
    - First word: LBI `{5'b11000, rd, data[15:8]}`, `out_last=0`, go to EMIT_HI.
    - When that word is accepted, present SLBI `{5'b10010, rd, data[7:0]}` with `out_last=1` and go to EMIT_LO.
    - Return to IDLE when SLBI is accepted.
  - Halt: `out_instr=16'h0000`, `out_last=1`. On acceptance: `halted=1` and state HALTED.
  - Nop: `out_instr=NOP_WORD`, `out_last=1`.
- HALTED: `req_ready=0`; no further words; only `rst` exits.
- `instr_count` increments on every `out_valid && out_ready`.

## Timing
- Reset (async assert, sync release):
  - State IDLE.
  - `out_valid=0`, `out_instr=0`, `out_last=0`.
  - `instr_count=0`, `halted=0`, `err=0`.
  - `req_ready` evaluates to 1 after release.
- Latency: request accepted on edge N → `out_valid=1` from N+1.
- Second word of a pair: `out_valid` stays high; the SLBI appears the cycle after the LBI handshake edge.
- Throughput: one word per cycle, with no bubble for back-to-back single-word requests when `out_ready=1`.
- `out_instr`/`out_last` are stable while `out_valid && !out_ready`.
- Simultaneous hand-off and accept in IDLE: the new word replaces the old in the same edge.
- Reset during EMIT_HI/EMIT_LO drops the pending word. No partial pair is emitted after reset.
- `err` sets on the accept edge and stays set until reset.

## Structure
- Shared package `wisc_pkg`:
  - opcode constants OP_HALT, OP_NOP, OP_LBI, OP_SLBI.
  - request-kind constants REQ_RAW, REQ_LDC, REQ_HALT, REQ_NOP.
  - state encoding.
- One sub-module, `imm_fit8`: combinational test that a 16-bit value is representable as a sign-extended 8-bit immediate.
- The output register and FSM live in `instr_word_encoder`.

## Test plan
- Reset then ldc rd=3, data 16'h0042, `out_ready=1`:
  - one word 16'hC342, `out_last=1`, `instr_count=1`.
- ldc rd=5, data 16'h1234:
  - 16'hC512 (`out_last=0`) then 16'h9534 (`out_last=1`) on consecutive cycles.
  - `req_ready=0` between the two words.
- ldc rd=1, data 16'hFF80:
  - single word 16'hC180.
- Same ldc 16'h1234 with `out_ready` low for 3 cycles on each word:
  - words held stable; `instr_count` advances only on handshakes; final count +2.
- raw 16'h0123:
  - emits 16'h0800; `err=1` persists.
  - then raw 16'h4A21 passes unchanged.
- halt then further `req_valid`:
  - 16'h0000 emitted; `halted=1`; `req_ready` stays 0.
  - `rst` low mid-pair clears all outputs and returns to IDLE.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared WISC-SP19 encoding constants, request kinds and encoder state encoding.
package wisc_pkg;

    // Opcode field values (instruction bits [15:11])
    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;
    localparam logic [4:0] OP_LBI  = 5'b11000;
    localparam logic [4:0] OP_SLBI = 5'b10010;

    // Full word emitted for nop requests and for scrubbed raw HALT words
    localparam logic [15:0] NOP_WORD = 16'h0800;

    // Request kinds on req_kind
    localparam logic [1:0] REQ_RAW  = 2'b00;
    localparam logic [1:0] REQ_LDC  = 2'b01;
    localparam logic [1:0] REQ_HALT = 2'b10;
    localparam logic [1:0] REQ_NOP  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_EMIT_HI = 2'b01,
        ST_EMIT_LO = 2'b10,
        ST_HALTED  = 2'b11
    } enc_state_t;

endpackage

// File: rtl/instr_word_encoder_imm_fit8.sv
// Tells whether a 16-bit value survives a round trip through a sign-extended
// 8-bit immediate, i.e. a single LBI is enough to load it.
module imm_fit8 (
    input  logic [15:0] value,
    output logic        fits
);

    // Bits [15:7] must all equal the immediate's sign bit
    always_comb begin
        fits = (value[15:7] == 9'h000) || (value[15:7] == 9'h1FF);
    end

endmodule

// File: rtl/instr_word_encoder.sv
// Turns abstract requests (raw word, load constant, halt, nop) into a stream of
// WISC-SP19 instruction words over a valid/ready output with a single register stage.
module instr_word_encoder
    import wisc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_kind,
    input  logic [2:0]  req_rd,
    input  logic [15:0] req_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic        out_last,
    output logic [15:0] instr_count,
    output logic        halted,
    output logic        err
);

    enc_state_t  state;
    logic [15:0] lo_word;   // SLBI half of a split constant, held until the LBI leaves
    logic        fits;
    logic        accept;
    logic        hand_off;

    imm_fit8 u_fit (
        .value (req_data),
        .fits  (fits)
    );

    // New requests only enter when idle and the output slot is free or draining now
    always_comb begin
        req_ready = (state == ST_IDLE) && (!out_valid || out_ready);
        accept    = req_valid && req_ready;
        hand_off  = out_valid && out_ready;
    end

    // FSM plus output register; every output word is registered here
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            out_valid   <= 1'b0;
            out_instr   <= 16'h0000;
            out_last    <= 1'b0;
            lo_word     <= 16'h0000;
            instr_count <= 16'h0000;
            halted      <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (hand_off) instr_count <= instr_count + 16'd1;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        // Loading over a word that leaves this same edge: no bubble
                        out_valid <= 1'b1;
                        out_last  <= 1'b1;
                        case (req_kind)
                            REQ_RAW: begin
                                // A raw HALT would end the program early; scrub it and flag
                                if (req_data[15:11] == OP_HALT) begin
                                    out_instr <= NOP_WORD;
                                    err       <= 1'b1;
                                end else begin
                                    out_instr <= req_data;
                                end
                            end
                            REQ_LDC: begin
                                if (fits) begin
                                    out_instr <= {OP_LBI, req_rd, req_data[7:0]};
                                end else begin
                                    out_instr <= {OP_LBI, req_rd, req_data[15:8]};
                                    out_last  <= 1'b0;
                                    lo_word   <= {OP_SLBI, req_rd, req_data[7:0]};
                                    state     <= ST_EMIT_HI;
                                end
                            end
                            REQ_HALT: begin
                                out_instr <= {OP_HALT, 11'd0};
                                state     <= ST_HALTED;
                            end
                            default: begin
                                out_instr <= NOP_WORD;
                            end
                        endcase
                    end else if (hand_off) begin
                        out_valid <= 1'b0;
                    end
                end
                ST_EMIT_HI: begin
                    // LBI taken: swap in the SLBI, out_valid stays high
                    if (hand_off) begin
                        out_instr <= lo_word;
                        out_last  <= 1'b1;
                        state     <= ST_EMIT_LO;
                    end
                end
                ST_EMIT_LO: begin
                    if (hand_off) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_HALTED: begin
                    // Stays here until reset; halted rises once the HALT word is taken
                    if (hand_off) begin
                        out_valid <= 1'b0;
                        halted    <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_word_encoder.sv
// Self-checking bench: directed scenarios plus randomized traffic, checked by a
// word-queue reference model that follows the request rules arithmetically.
module tb_instr_word_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_kind = 2'b00;
    logic [2:0]  req_rd = 3'd0;
    logic [15:0] req_data = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic        out_last;
    logic [15:0] instr_count;
    logic        halted;
    logic        err;

    int checks = 0;
    int errors = 0;

    instr_word_encoder dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_kind    (req_kind),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_last    (out_last),
        .instr_count (instr_count),
        .halted      (halted),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] w;
        logic        last;
        logic        second;   // trailing word of a split constant
        logic        is_halt;
    } exp_t;

    exp_t        q[$];
    logic [15:0] exp_cnt = 16'h0;
    logic        exp_halted = 1'b0;
    logic        exp_err = 1'b0;
    logic        halt_req = 1'b0;

    function automatic exp_t mk(input logic [15:0] w, input logic last, input logic second,
                                input logic is_halt);
        exp_t e;
        e.w = w; e.last = last; e.second = second; e.is_halt = is_halt;
        return e;
    endfunction

    // Expected words for one request, from the request rules
    task automatic model_push(input logic [1:0] kind, input logic [2:0] rd, input logic [15:0] d);
        int v;
        case (kind)
            2'd0: begin
                if (d[15:11] == 5'd0) begin
                    q.push_back(mk(16'h0800, 1'b1, 1'b0, 1'b0));
                    exp_err = 1'b1;
                end else begin
                    q.push_back(mk(d, 1'b1, 1'b0, 1'b0));
                end
            end
            2'd1: begin
                v = $signed(d);
                if (v >= -128 && v <= 127) begin
                    q.push_back(mk({5'b11000, rd, d[7:0]}, 1'b1, 1'b0, 1'b0));
                end else begin
                    q.push_back(mk({5'b11000, rd, d[15:8]}, 1'b0, 1'b0, 1'b0));
                    q.push_back(mk({5'b10010, rd, d[7:0]}, 1'b1, 1'b1, 1'b0));
                end
            end
            2'd2: begin
                q.push_back(mk(16'h0000, 1'b1, 1'b0, 1'b1));
                halt_req = 1'b1;
            end
            default: q.push_back(mk(16'h0800, 1'b1, 1'b0, 1'b0));
        endcase
    endtask

    // Per-cycle scoreboard, sampled mid-cycle away from the active edge
    always @(negedge clk) begin
        logic exp_ready;
        exp_t e;
        if (!rst) begin
            q.delete();
            exp_cnt = 16'h0; exp_halted = 1'b0; exp_err = 1'b0; halt_req = 1'b0;
        end else begin
            exp_ready = !halt_req &&
                        (q.size() == 0 || (q.size() == 1 && !q[0].second && out_ready));
            chk("mon_out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("mon_out_instr", 32'(out_instr), 32'(q[0].w));
                chk("mon_out_last", 32'(out_last), 32'(q[0].last));
            end
            chk("mon_req_ready", 32'(req_ready), 32'(exp_ready));
            chk("mon_instr_count", 32'(instr_count), 32'(exp_cnt));
            chk("mon_halted", 32'(halted), 32'(exp_halted));
            chk("mon_err", 32'(err), 32'(exp_err));
            if (q.size() != 0 && out_ready) begin
                e = q.pop_front();
                exp_cnt = exp_cnt + 16'd1;
                if (e.is_halt) exp_halted = 1'b1;
            end
            if (req_valid && exp_ready) model_push(req_kind, req_rd, req_data);
        end
    end

    // Randomized consumer back-pressure when enabled
    logic rnd_ready = 1'b0;
    always @(posedge clk) begin
        if (rnd_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Present a request at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [1:0] kind, input logic [2:0] rd, input logic [15:0] d);
        int n = 0;
        req_valid = 1'b1; req_kind = kind; req_rd = rd; req_data = d;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 100) begin
                chk("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic [15:0] d;
        logic [1:0]  k;

        // Reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", 32'(out_instr), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_instr_count", 32'(instr_count), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // ldc small constant: single LBI
        out_ready = 1'b1;
        send(2'd1, 3'd3, 16'h0042);
        @(negedge clk);
        chk("ldc42_instr", 32'(out_instr), 32'hC342);
        chk("ldc42_last", 32'(out_last), 32'd1);
        @(negedge clk);
        chk("ldc42_count", 32'(instr_count), 32'd1);
        @(posedge clk); #1;

        // ldc wide constant: LBI then SLBI on consecutive cycles
        send(2'd1, 3'd5, 16'h1234);
        @(negedge clk);
        chk("pair_hi_instr", 32'(out_instr), 32'hC512);
        chk("pair_hi_last", 32'(out_last), 32'd0);
        chk("pair_hi_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("pair_lo_instr", 32'(out_instr), 32'h9534);
        chk("pair_lo_last", 32'(out_last), 32'd1);
        chk("pair_lo_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;

        // Negative constant that fits in 8 bits
        send(2'd1, 3'd1, 16'hFF80);
        @(negedge clk);
        chk("ldcff80_instr", 32'(out_instr), 32'hC180);
        @(posedge clk); #1;

        // Stalled pair: 3 cycles of back-pressure on each word
        out_ready = 1'b0;
        send(2'd1, 3'd5, 16'h1234);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_count", 32'(instr_count), 32'd6);
        @(posedge clk); #1;

        // Raw HALT opcode is scrubbed and flagged; a legal raw word passes
        send(2'd0, 3'd0, 16'h0123);
        @(negedge clk);
        chk("raw0123_instr", 32'(out_instr), 32'h0800);
        chk("raw0123_err", 32'(err), 32'd1);
        @(posedge clk); #1;
        send(2'd0, 3'd0, 16'h4A21);
        @(negedge clk);
        chk("raw4a21_instr", 32'(out_instr), 32'h4A21);
        chk("err_sticky", 32'(err), 32'd1);
        @(posedge clk); #1;

        // Back-to-back nops with out_ready high
        send(2'd3, 3'd0, 16'h0000);
        send(2'd3, 3'd0, 16'h0000);
        @(negedge clk);
        chk("b2b_count", 32'(instr_count), 32'd9);
        @(posedge clk); #1;

        // Randomized traffic under random back-pressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            n = $urandom_range(0, 2);
            k = (n == 0) ? 2'd0 : (n == 1) ? 2'd1 : 2'd3;
            d = 16'($urandom);
            if ($urandom_range(0, 3) == 0) d = {{9{d[7]}}, d[6:0]};
            if ($urandom_range(0, 7) == 0) d[15:11] = 5'd0;
            send(k, 3'($urandom), d);
        end
        rnd_ready = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_done", 32'(q.size()), 32'd0);

        // Halt, then further requests are refused
        send(2'd2, 3'd0, 16'h0000);
        @(negedge clk);
        chk("halt_instr", 32'(out_instr), 32'h0000);
        @(posedge clk); #1;
        req_valid = 1'b1; req_kind = 2'd3;
        repeat (5) begin
            @(negedge clk);
            chk("halt_ready_low", 32'(req_ready), 32'd0);
            chk("halt_no_word", 32'(out_valid), 32'd0);
            chk("halt_flag", 32'(halted), 32'd1);
        end
        @(posedge clk); #1 req_valid = 1'b0;

        // Reset mid-pair drops the pending SLBI
        rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        out_ready = 1'b1;
        send(2'd1, 3'd2, 16'hABCD);
        #2 rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_instr", 32'(out_instr), 32'd0);
        chk("midrst_count", 32'(instr_count), 32'd0);
        chk("midrst_halted", 32'(halted), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("postrst_no_word", 32'(out_valid), 32'd0);
            chk("postrst_ready", 32'(req_ready), 32'd1);
        end
        chk("postrst_count", 32'(instr_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
